// File: rtl/vga_pixpack_if.sv
// Pixel-packer port bundle: RGB FIFO read side, pixel-buffer write side and packing controls.
// master drives pixels, depth, flush and buffer-full; slave is the packer.
interface vga_pixpack_if;
  logic [1:0]  ColorDepth;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;
  logic        rgb_fifo_empty;
  logic        rgb_fifo_rreq;
  logic        flush;
  logic        pixel_buffer_full;
  logic        pixel_buffer_wreq;
  logic [31:0] pixel_buffer_do;

  modport master (
    output ColorDepth, R, G, B, rgb_fifo_empty, flush, pixel_buffer_full,
    input  rgb_fifo_rreq, pixel_buffer_wreq, pixel_buffer_do
  );

  modport slave (
    input  ColorDepth, R, G, B, rgb_fifo_empty, flush, pixel_buffer_full,
    output rgb_fifo_rreq, pixel_buffer_wreq, pixel_buffer_do
  );
endinterface

// File: rtl/vga_pixpack.sv
// Packs FWFT RGB pixels into 32-bit words (8bpp grey, 16bpp 5-6-5, 24bpp); word valid one clk after its last pixel.
// Pops stop while a pending write is blocked by pixel_buffer_full; VGA_PACK_LUMA_EN selects luma grey for 8bpp.
module vga_pixpack (
  input  logic         clk,
  input  logic         nrst,
  vga_pixpack_if.slave pp
);

  typedef enum logic {
    PACK  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state;
  logic [1:0]  pcnt;
  logic [1:0]  cdepth;
  logic [23:0] carry;
  logic        wreq;
  logic [31:0] dout;

  logic        stall;
  logic        pop;
  logic [1:0]  depth;
  logic [7:0]  grey;
  logic [15:0] rgb565;

  logic        pix_done;
  logic [31:0] pix_word;
  logic [23:0] pix_carry;
  logic [1:0]  pix_pcnt;

  assign stall = wreq & pp.pixel_buffer_full;
  assign pop   = nrst & ~pp.rgb_fifo_empty & ~stall & (state == PACK) & ~pp.flush;

  // The first pixel of a group uses the live depth; later pixels stay on the latched one.
  assign depth = (pcnt == 2'd0) ? pp.ColorDepth : cdepth;

`ifdef VGA_PACK_LUMA_EN
  assign grey = 8'((16'd77  * {8'd0, pp.R} +
                    16'd150 * {8'd0, pp.G} +
                    16'd29  * {8'd0, pp.B}) >> 8);
`else
  assign grey = pp.R;
`endif

  assign rgb565 = {pp.R[7:3], pp.G[7:2], pp.B[7:3]};

  // Unfilled carry bytes are kept at zero so a flushed partial word is always {carry, 8'h00}.
  always_comb begin
    pix_done  = 1'b0;
    pix_word  = 32'd0;
    pix_carry = carry;
    pix_pcnt  = pcnt + 2'd1;
    case (depth)
      2'b00: begin
        case (pcnt)
          2'd0: pix_carry = {grey, 16'd0};
          2'd1: pix_carry = {carry[23:16], grey, 8'd0};
          2'd2: pix_carry = {carry[23:8], grey};
          default: begin
            pix_done  = 1'b1;
            pix_word  = {carry, grey};
            pix_carry = 24'd0;
          end
        endcase
      end
      2'b01: begin
        if (pcnt == 2'd0) begin
          pix_carry = {rgb565, 8'd0};
        end else begin
          pix_done  = 1'b1;
          pix_word  = {carry[23:8], rgb565};
          pix_carry = 24'd0;
          pix_pcnt  = 2'd0;
        end
      end
      default: begin
        case (pcnt)
          2'd0: pix_carry = {pp.R, pp.G, pp.B};
          2'd1: begin
            pix_done  = 1'b1;
            pix_word  = {carry, pp.R};
            pix_carry = {pp.G, pp.B, 8'd0};
          end
          2'd2: begin
            pix_done  = 1'b1;
            pix_word  = {carry[23:8], pp.R, pp.G};
            pix_carry = {pp.B, 16'd0};
          end
          default: begin
            pix_done  = 1'b1;
            pix_word  = {carry[23:16], pp.R, pp.G, pp.B};
            pix_carry = 24'd0;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= PACK;
      pcnt   <= 2'd0;
      cdepth <= 2'b00;
      carry  <= 24'd0;
      wreq   <= 1'b0;
      dout   <= 32'd0;
    end else begin
      if (pcnt == 2'd0) begin
        cdepth <= pp.ColorDepth;
      end
      if (wreq && !pp.pixel_buffer_full) begin
        wreq <= 1'b0;
      end
      case (state)
        PACK: begin
          if (pp.flush) begin
            if (pcnt != 2'd0) begin
              if (stall) begin
                state <= FLUSH;
              end else begin
                dout  <= {carry, 8'd0};
                wreq  <= 1'b1;
                pcnt  <= 2'd0;
                carry <= 24'd0;
              end
            end
          end else if (pop) begin
            pcnt  <= pix_pcnt;
            carry <= pix_carry;
            if (pix_done) begin
              dout <= pix_word;
              wreq <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (!stall) begin
            dout  <= {carry, 8'd0};
            wreq  <= 1'b1;
            pcnt  <= 2'd0;
            carry <= 24'd0;
            state <= PACK;
          end
        end
        default: state <= PACK;
      endcase
    end
  end

  assign pp.rgb_fifo_rreq     = pop;
  assign pp.pixel_buffer_wreq = wreq;
  assign pp.pixel_buffer_do   = dout;

endmodule

// File: tb/tb_vga_pixpack.sv
// Directed bench for vga_pixpack: pixel queue models the FWFT FIFO, expected words are scoreboarded.
module tb_vga_pixpack;
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  vga_pixpack_if pp ();
  vga_pixpack dut (.clk(clk), .nrst(nrst), .pp(pp));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int writes = 0;
  int wreq_cycles = 0;
  logic [23:0] pix_q[$];
  logic [31:0] exp_q[$];
  int wcyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gry(input logic [23:0] p);
`ifdef VGA_PACK_LUMA_EN
    int s;
    s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
    return 8'(s >> 8);
`else
    return p[23:16];
`endif
  endfunction

  function automatic logic [15:0] p565(input logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction

  task automatic drive_src();
    pp.rgb_fifo_empty = (pix_q.size() == 0);
    if (pix_q.size() != 0) {pp.R, pp.G, pp.B} = pix_q[0];
  endtask

  // Called just after a falling edge; samples what the coming rising edge will do.
  task automatic tick();
    #1;
    if (pp.rgb_fifo_rreq) begin
      if (pix_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL pop_empty: observed rreq=1 expected rreq=0");
      end else begin
        void'(pix_q.pop_front());
      end
    end
    if (pp.pixel_buffer_wreq && !pp.pixel_buffer_full) begin
      writes++;
      wcyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL spurious_write: observed=%h expected=none", pp.pixel_buffer_do);
      end else begin
        chk("write_data", pp.pixel_buffer_do, exp_q.pop_front());
      end
    end
    if (pp.pixel_buffer_wreq) wreq_cycles++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    pp.flush = 1'b0;
    drive_src();
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || pix_q.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pop_all(input int bound);
    int n = 0;
    while (pix_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_wreq(input string tag, input int bound);
    int n = 0;
    while (!pp.pixel_buffer_wreq && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_wreq_seen"}, 32'(pp.pixel_buffer_wreq), 32'd1);
  endtask

  initial begin
    int c0;
    int w0;
    logic [23:0] px[4];

    nrst = 1'b1;
    pp.ColorDepth = 2'b00;
    {pp.R, pp.G, pp.B} = 24'h0;
    pp.rgb_fifo_empty = 1'b0;
    pp.flush = 1'b0;
    pp.pixel_buffer_full = 1'b0;
    #1 nrst = 1'b0;
    #1;
    chk("rst_wreq", 32'(pp.pixel_buffer_wreq), 32'd0);
    chk("rst_do", pp.pixel_buffer_do, 32'd0);
    chk("rst_rreq", 32'(pp.rgb_fifo_rreq), 32'd0);
    @(negedge clk);
    @(negedge clk);
    drive_src();
    nrst = 1'b1;

    // 8bpp: G/B deliberately non-zero
    pp.ColorDepth = 2'b00;
    px = '{24'h115AA5, 24'h225AA5, 24'h335AA5, 24'h445AA5};
    foreach (px[i]) pix_q.push_back(px[i]);
`ifdef VGA_PACK_LUMA_EN
    exp_q.push_back({gry(px[0]), gry(px[1]), gry(px[2]), gry(px[3])});
`else
    exp_q.push_back(32'h11223344);
`endif
    drive_src();
    wreq_cycles = 0;
    wcyc.delete();
    c0 = cyc;
    drain("b8", 40);
    chk("b8_wreq_cycles", 32'(wreq_cycles), 32'd1);
    chk("b8_writes", 32'(wcyc.size()), 32'd1);
    if (wcyc.size() > 0) chk("b8_latency", 32'(wcyc[0] - c0), 32'd4);

    // 16bpp
    pp.ColorDepth = 2'b01;
    pix_q.push_back(24'hF8FCF8);
    pix_q.push_back(24'h080408);
    exp_q.push_back(32'hFFFF0821);
    drive_src();
    drain("b16", 40);

    // 24bpp: three back-to-back words
    pp.ColorDepth = 2'b10;
    pix_q.push_back(24'h010203);
    pix_q.push_back(24'h040506);
    pix_q.push_back(24'h070809);
    pix_q.push_back(24'h0A0B0C);
    exp_q.push_back(32'h01020304);
    exp_q.push_back(32'h05060708);
    exp_q.push_back(32'h090A0B0C);
    drive_src();
    wcyc.delete();
    drain("b24", 40);
    chk("b24_writes", 32'(wcyc.size()), 32'd3);
    if (wcyc.size() == 3) begin
      chk("b24_gap01", 32'(wcyc[1] - wcyc[0]), 32'd1);
      chk("b24_gap12", 32'(wcyc[2] - wcyc[1]), 32'd1);
    end

    // flush with an empty group writes nothing
    w0 = writes;
    pp.flush = 1'b1;
    tick();
    tick();
    tick();
    chk("flush_idle_nowrite", 32'(writes - w0), 32'd0);

    // 24bpp flush after two pixels
    pix_q.push_back(24'h010203);
    pix_q.push_back(24'h040506);
    exp_q.push_back(32'h01020304);
    exp_q.push_back(32'h05060000);
    drive_src();
    pop_all(10);
    pp.flush = 1'b1;
    tick();
    drain("flush24", 40);

    // backpressure in 8bpp
    pp.ColorDepth = 2'b00;
    pp.pixel_buffer_full = 1'b1;
    for (int i = 0; i < 8; i++) pix_q.push_back({8'(8'h10 + i), 16'h0});
    exp_q.push_back({gry(24'h100000), gry(24'h110000), gry(24'h120000), gry(24'h130000)});
    exp_q.push_back({gry(24'h140000), gry(24'h150000), gry(24'h160000), gry(24'h170000)});
    drive_src();
    wait_wreq("bp", 20);
    chk("bp_popped", 32'(pix_q.size()), 32'd4);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rreq_held", 32'(pp.rgb_fifo_rreq), 32'd0);
      chk("bp_do_stable", pp.pixel_buffer_do, exp_q[0]);
      tick();
    end
    pp.pixel_buffer_full = 1'b0;
    drain("bp", 40);

    // depth change mid-group waits for the group boundary
    pp.ColorDepth = 2'b01;
    pix_q.push_back(24'hF0F0F0);
    drive_src();
    pop_all(10);
    pp.ColorDepth = 2'b00;
    px = '{24'h0C0000, 24'h0D0000, 24'h0E0000, 24'h0F0000};
    pix_q.push_back(24'h0F0F0F);
    foreach (px[i]) pix_q.push_back(px[i]);
    exp_q.push_back({p565(24'hF0F0F0), p565(24'h0F0F0F)});
    exp_q.push_back({gry(px[0]), gry(px[1]), gry(px[2]), gry(px[3])});
    drive_src();
    drain("depth", 40);

    // flush while stalled parks in FLUSH, writes on release
    pp.ColorDepth = 2'b10;
    pp.pixel_buffer_full = 1'b1;
    pix_q.push_back(24'h212223);
    pix_q.push_back(24'h242526);
    pix_q.push_back(24'h313233);
    exp_q.push_back(32'h21222324);
    exp_q.push_back(32'h25260000);
    exp_q.push_back(32'h31323300);
    drive_src();
    wait_wreq("fstall", 20);
    pp.flush = 1'b1;
    tick();
    #1;
    chk("fstall_rreq", 32'(pp.rgb_fifo_rreq), 32'd0);
    pp.flush = 1'b1;
    tick();
    pp.pixel_buffer_full = 1'b0;
    #1;
    chk("fstate_no_pop", 32'(pp.rgb_fifo_rreq), 32'd0);
    tick();
    pop_all(10);
    pp.flush = 1'b1;
    tick();
    drain("fstall", 40);

    // async reset mid-word discards the partial word
    pp.ColorDepth = 2'b00;
    pix_q.push_back(24'hAA0000);
    pix_q.push_back(24'hBB0000);
    drive_src();
    pop_all(10);
    pix_q.push_back(24'h010000);
    drive_src();
    #3 nrst = 1'b0;
    #1;
    chk("arst_wreq", 32'(pp.pixel_buffer_wreq), 32'd0);
    chk("arst_rreq", 32'(pp.rgb_fifo_rreq), 32'd0);
    chk("arst_do", pp.pixel_buffer_do, 32'd0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    w0 = writes;
    tick();
    tick();
    chk("arst_nowrite", 32'(writes - w0), 32'd0);
    pix_q.push_back(24'h020000);
    pix_q.push_back(24'h030000);
    pix_q.push_back(24'h040000);
    exp_q.push_back({gry(24'h010000), gry(24'h020000), gry(24'h030000), gry(24'h040000)});
    drive_src();
    drain("arst", 40);

    // grey extremes
    pix_q.push_back(24'hFF0000);
    pix_q.push_back(24'hFFFFFF);
    pix_q.push_back(24'hFF0000);
    pix_q.push_back(24'hFFFFFF);
`ifdef VGA_PACK_LUMA_EN
    exp_q.push_back(32'h4CFF4CFF);
`else
    exp_q.push_back(32'hFFFFFFFF);
`endif
    drive_src();
    drain("luma", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
